// File: rtl/boot_mem_ctrl.sv
// boot_mem_ctrl: boot-time RAM controller.
// A loader fills the RAM while the core is held in reset, a programmable
// settle delay follows, then the core is released and owns the RAM through
// a single-cycle request / one-cycle response port.
// Optional feature: define BOOT_CHECKSUM_EN to build the loader checksum
// accumulator; otherwise boot_sum is tied to zero.
module boot_mem_ctrl #(
  parameter int MEM_WORDS     = 1024,
  parameter int RELEASE_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        ld_we,
  input  logic        ld_done,
  output logic        cpu_rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic [15:0] boot_words,
  output logic [31:0] boot_sum,
  output logic        addr_err
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {LOAD, SETTLE, RUN} state_t;

  // A byte address is usable when word-aligned and inside the RAM.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < 32'(MEM_WORDS));
  endfunction

  // Word counter increments but sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DATA_W-1:0] mem [MEM_WORDS];

  state_t state, state_next;
  logic [7:0] cnt, cnt_next;

  logic ld_acc, ld_bad, cpu_go, cpu_ok;
  logic [AW-1:0] ld_idx, cpu_idx;

  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [3:0]        wr_be;

  logic              rvalid_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic [15:0]       words_q;
  logic              err_q;

  assign ld_idx  = ld_addr[AW+1:2];
  assign cpu_idx = cpu_addr[AW+1:2];
  assign cpu_ok  = addr_ok(cpu_addr);
  assign ld_acc  = (state == LOAD) && ld_we && addr_ok(ld_addr);
  assign ld_bad  = (state == LOAD) && ld_we && !addr_ok(ld_addr);
  assign cpu_go  = (state == RUN) && cpu_req;

  // Next-state logic: LOAD waits for ld_done, SETTLE counts down, RUN is terminal.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      LOAD: begin
        cnt_next = 8'(RELEASE_DELAY);
        if (ld_done) state_next = SETTLE;
      end
      SETTLE: begin
        if (cnt <= 8'd1) state_next = RUN;
        else             cnt_next   = cnt - 8'd1;
      end
      RUN:     state_next = RUN;
      default: state_next = LOAD;
    endcase
  end

  // State, settle counter and the registered core reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      cnt       <= 8'(RELEASE_DELAY);
      cpu_rst_n <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cpu_rst_n <= (state_next == RUN);
    end
  end

  // Single RAM write port shared by loader (LOAD only) and core (RUN only).
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    wr_be   = 4'h0;
    if (ld_acc) begin
      wr_en   = 1'b1;
      wr_idx  = ld_idx;
      wr_data = ld_wdata;
      wr_be   = 4'hF;
    end else if (cpu_go && cpu_we && cpu_ok) begin
      wr_en   = 1'b1;
      wr_idx  = cpu_idx;
      wr_data = cpu_wdata;
      wr_be   = cpu_wstrb;
    end
  end

  // RAM array: byte-enabled write, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Stage p1: core response one cycle after the request; bad addresses read zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_p1 <= 1'b0;
      rdata_p1  <= '0;
    end else begin
      rvalid_p1 <= cpu_go;
      if (cpu_go) rdata_p1 <= (!cpu_we && cpu_ok) ? mem[cpu_idx] : '0;
    end
  end

  assign cpu_rvalid = rvalid_p1;
  assign cpu_rdata  = rdata_p1;

  // Loader word count and sticky address error from either port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (ld_acc) words_q <= sat_inc(words_q);
      if (ld_bad || (cpu_go && !cpu_ok)) err_q <= 1'b1;
    end
  end

  assign boot_words = words_q;
  assign addr_err   = err_q;

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Running mod-2^32 sum of every accepted loader word.
  always_ff @(posedge clk) begin
    if (!rst_n)      sum_q <= '0;
    else if (ld_acc) sum_q <= sum_q + ld_wdata;
  end

  assign boot_sum = sum_q;
`else
  assign boot_sum = 32'h0;
`endif

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// Self-checking bench for boot_mem_ctrl: directed scenarios plus a randomized
// load/run phase checked against an array-based reference model.
module tb_boot_mem_ctrl;

  localparam int MW = 64;
  localparam int RD = 3;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ld_addr = '0, ld_wdata = '0;
  logic        ld_we = 1'b0, ld_done = 1'b0;
  logic        cpu_rst_n;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic [15:0] boot_words;
  logic [31:0] boot_sum;
  logic        addr_err;

  boot_mem_ctrl #(.MEM_WORDS(MW), .RELEASE_DELAY(RD)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_we(ld_we), .ld_done(ld_done),
    .cpu_rst_n(cpu_rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .boot_words(boot_words), .boot_sum(boot_sum), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: RAM image, which words hold a defined value, loader stats.
  logic [31:0] ref_mem [MW];
  bit          ref_known [MW];
  int          ref_words;
  logic [31:0] ref_sum;
  bit          ref_err;

  function automatic bit m_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a < 32'(MW * 4));
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_sum();
    return CK_EN ? ref_sum : 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_we = 1'b0; ld_done = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ref_words = 0; ref_sum = '0; ref_err = 1'b0;
  endtask

  // One loader beat; model applies the accept/drop rule.
  task automatic ld_write(input logic [31:0] a, input logic [31:0] d, input bit done);
    ld_we = 1'b1; ld_addr = a; ld_wdata = d; ld_done = done;
    tick();
    ld_we = 1'b0; ld_done = 1'b0;
    if (m_ok(a)) begin
      ref_mem[a / 4] = d; ref_known[a / 4] = 1'b1;
      ref_words = (ref_words < 65535) ? ref_words + 1 : 65535;
      ref_sum = ref_sum + d;
    end else begin
      ref_err = 1'b1;
    end
  endtask

  task automatic finish_load();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    repeat (RD) tick();
  endtask

  // One core request; on return the response cycle is being observed.
  task automatic cpu_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    if (!m_ok(a)) ref_err = 1'b1;
    else if (we) begin
      ref_mem[a / 4] = m_merge(ref_mem[a / 4], d, s);
      if (s == 4'hF) ref_known[a / 4] = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_rst_n got %0b want 0", cpu_rst_n); end
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %0b want 0", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", cpu_rdata); end
    n_checks++; if (boot_words !== 16'h0) begin n_fail++; $display("FAIL rst_words got %0d want 0", boot_words); end
    n_checks++; if (boot_sum !== 32'h0) begin n_fail++; $display("FAIL rst_sum got %h want 0", boot_sum); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL rst_addr_err got %0b want 0", addr_err); end
  endtask

  task automatic test_load_release();
    ld_write(32'h0, 32'h0010_0093, 1'b0);
    ld_write(32'h4, 32'h0020_0113, 1'b0);
    n_checks++; if (boot_words !== 16'd2) begin n_fail++; $display("FAIL load_words got %0d want 2", boot_words); end
    n_checks++; if (boot_sum !== (CK_EN ? 32'h0030_01A6 : 32'h0)) begin n_fail++; $display("FAIL load_sum got %h want %h", boot_sum, CK_EN ? 32'h0030_01A6 : 32'h0); end
    n_checks++; if (boot_sum !== exp_sum()) begin n_fail++; $display("FAIL load_sum_model got %h want %h", boot_sum, exp_sum()); end
    ld_done = 1'b1;
    for (int k = 1; k <= RD + 1; k++) begin
      tick();
      ld_done = 1'b0;
      n_checks++; if (cpu_rst_n !== (k == RD + 1)) begin n_fail++; $display("FAIL release_k%0d got %0b want %0b", k, cpu_rst_n, k == RD + 1); end
      n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL settle_rvalid_k%0d got %0b want 0", k, cpu_rvalid); end
      if (k <= RD) begin
        ld_we = 1'b1; ld_addr = 32'h8; ld_wdata = 32'hDEAD_BEEF;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
      end else idle();
    end
    tick();
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL settle_req_rvalid got %0b want 0", cpu_rvalid); end
    n_checks++; if (boot_words !== 16'd2) begin n_fail++; $display("FAIL settle_ldwe_words got %0d want 2", boot_words); end
  endtask

  task automatic test_read();
    cpu_op(1'b0, 32'h4, 32'h0, 4'h0);
    n_checks++; if (cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL read_rvalid got %0b want 1", cpu_rvalid); end
    n_checks++; if (cpu_rdata !== 32'h0020_0113) begin n_fail++; $display("FAIL read_data got %h want 00200113", cpu_rdata); end
    tick();
    n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_pulse got %0b want 0", cpu_rvalid); end
  endtask

  task automatic test_strobe_write();
    cpu_op(1'b1, 32'h0, 32'h0, 4'hF);
    n_checks++; if (cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL wr_ack got %0b want 1", cpu_rvalid); end
    cpu_op(1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101);
    cpu_op(1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++; if (cpu_rdata !== 32'h00BB_00DD || cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL strobe_read got %h/%0b want 00bb00dd/1", cpu_rdata, cpu_rvalid); end
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL good_access_err got %0b want 0", addr_err); end
  endtask

  task automatic test_cpu_bad();
    cpu_op(1'b0, 32'h6, 32'h0, 4'h0);
    n_checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL bad_read got %h/%0b want 0/1", cpu_rdata, cpu_rvalid); end
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL bad_read_err got %0b want 1", addr_err); end
    cpu_op(1'b1, 32'(MW * 4), 32'hFFFF_FFFF, 4'hF);
    cpu_op(1'b1, 32'h1, 32'hFFFF_FFFF, 4'hF);
    cpu_op(1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++; if (cpu_rdata !== 32'h00BB_00DD) begin n_fail++; $display("FAIL bad_write_untouched got %h want 00bb00dd", cpu_rdata); end
    cpu_op(1'b0, 32'(MW * 4 + 4), 32'h0, 4'h0);
    n_checks++; if (cpu_rdata !== 32'h0 || cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL oor_read got %h/%0b want 0/1", cpu_rdata, cpu_rvalid); end
  endtask

  task automatic test_ld_in_run();
    ld_we = 1'b1; ld_addr = 32'h4; ld_wdata = 32'h1234_5678; ld_done = 1'b1;
    tick();
    idle();
    n_checks++; if (boot_words !== 16'd2) begin n_fail++; $display("FAIL run_ldwe_words got %0d want 2", boot_words); end
    cpu_op(1'b0, 32'h4, 32'h0, 4'h0);
    n_checks++; if (cpu_rdata !== 32'h0020_0113) begin n_fail++; $display("FAIL run_ldwe_ram got %h want 00200113", cpu_rdata); end
    n_checks++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL run_sticky got %0b want 1", cpu_rst_n); end
  endtask

  task automatic test_bad_load();
    do_reset();
    ld_write(32'h0, 32'h1111_1111, 1'b0);
    n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL ld_good_err got %0b want 0", addr_err); end
    ld_write(32'h2, 32'h2222_2222, 1'b0);
    ld_write(32'(MW * 4), 32'h3333_3333, 1'b0);
    n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL ld_bad_err got %0b want 1", addr_err); end
    n_checks++; if (boot_words !== 16'd1) begin n_fail++; $display("FAIL ld_bad_words got %0d want 1", boot_words); end
    n_checks++; if (boot_sum !== exp_sum()) begin n_fail++; $display("FAIL ld_bad_sum got %h want %h", boot_sum, exp_sum()); end
    finish_load();
    cpu_op(1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++; if (cpu_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL ld_bad_ram got %h want 11111111", cpu_rdata); end
  endtask

  task automatic test_done_same_cycle();
    do_reset();
    ld_write(32'hC, 32'hCAFE_F00D, 1'b1);
    n_checks++; if (boot_words !== 16'd1) begin n_fail++; $display("FAIL done_same_words got %0d want 1", boot_words); end
    n_checks++; if (boot_sum !== exp_sum()) begin n_fail++; $display("FAIL done_same_sum got %h want %h", boot_sum, exp_sum()); end
    for (int k = 1; k <= RD; k++) begin
      tick();
      n_checks++; if (cpu_rst_n !== (k == RD)) begin n_fail++; $display("FAIL done_same_rel_k%0d got %0b want %0b", k, cpu_rst_n, k == RD); end
    end
    cpu_op(1'b0, 32'hC, 32'h0, 4'h0);
    n_checks++; if (cpu_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL done_same_ram got %h want cafef00d", cpu_rdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    n_checks++; if (cpu_rst_n !== 1'b0 || boot_words !== 16'h0 || boot_sum !== 32'h0 || addr_err !== 1'b0) begin n_fail++; $display("FAIL midrun_reset got rst%0b w%0d s%h e%0b want 0/0/0/0", cpu_rst_n, boot_words, boot_sum, addr_err); end
    ld_write(32'h10, 32'h5555_AAAA, 1'b0);
    do_reset();
    n_checks++; if (boot_words !== 16'h0) begin n_fail++; $display("FAIL midload_reset_words got %0d want 0", boot_words); end
    finish_load();
    cpu_op(1'b0, 32'hC, 32'h0, 4'h0);
    n_checks++; if (cpu_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL retained_ram got %h want cafef00d", cpu_rdata); end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, MW - 1) * 4);
    else if (r == 7) return 32'($urandom_range(0, MW - 1) * 4 + $urandom_range(1, 3));
    else             return 32'(MW * 4 + $urandom_range(0, 255) * 4);
  endfunction

  task automatic test_random();
    logic [31:0] a, d;
    bit          we;
    logic [3:0]  s;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      ld_write(rand_addr(), $urandom, i == 39);
      n_checks++; if (boot_words !== 16'(ref_words) || boot_sum !== exp_sum() || addr_err !== ref_err) begin n_fail++; $display("FAIL rnd_load_%0d got w%0d s%h e%0b want w%0d s%h e%0b", i, boot_words, boot_sum, addr_err, ref_words, exp_sum(), ref_err); end
    end
    repeat (RD) tick();
    n_checks++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL rnd_release got %0b want 1", cpu_rst_n); end
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        tick();
        n_checks++; if (cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_%0d rvalid got %0b want 0", i, cpu_rvalid); end
      end else begin
        a = rand_addr(); d = $urandom; we = $urandom_range(0, 1) == 1;
        s = (we && $urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        if (!we && m_ok(a) && !ref_known[a / 4]) we = 1'b1;
        cpu_op(we, a, d, s);
        n_checks++; if (cpu_rvalid !== 1'b1 || addr_err !== ref_err) begin n_fail++; $display("FAIL rnd_op_%0d got v%0b e%0b want v1 e%0b", i, cpu_rvalid, addr_err, ref_err); end
        if (!we) begin
          n_checks++; if (cpu_rdata !== (m_ok(a) ? ref_mem[a / 4] : 32'h0)) begin n_fail++; $display("FAIL rnd_rd_%0d addr %h got %h want %h", i, a, cpu_rdata, m_ok(a) ? ref_mem[a / 4] : 32'h0); end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MW; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end
    test_reset();
    test_load_release();
    test_read();
    test_strobe_write();
    test_cpu_bad();
    test_ld_in_run();
    test_bad_load();
    test_done_same_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/boot_mem_ctrl.md
BOOT_MEM_CTRL -- requirements
Module: boot_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, giving the 32-bit word depth of the internal RAM (power of two).
REQ-002 SHALL have parameter RELEASE_DELAY, default 4, giving the SETTLE cycles between load completion and CPU reset release (1..255).
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 ld_addr  in  32  loader byte address.
REQ-006 ld_wdata  in  32  loader write word.
REQ-007 ld_we  in  1  loader write strobe, one word per cycle.
REQ-008 ld_done  in  1  loader finished (level).
REQ-009 cpu_rst_n  out  1  active-low reset to the core.
REQ-010 cpu_req  in  1  CPU access request, single cycle.
REQ-011 cpu_we  in  1  CPU write (1) / read (0).
REQ-012 cpu_addr  in  32  CPU byte address.
REQ-013 cpu_wdata  in  32  CPU write data.
REQ-014 cpu_wstrb  in  4  CPU byte enables; bit n enables byte n.
REQ-015 cpu_rdata  out  32  read data, valid with cpu_rvalid.
REQ-016 cpu_rvalid  out  1  one-cycle response/ack pulse.
REQ-017 boot_words  out  16  count of accepted loader writes.
REQ-018 boot_sum  out  32  mod-2^32 sum of accepted loader words.
REQ-019 addr_err  out  1  sticky bad-address flag.

Function
REQ-020 SHALL implement states LOAD, SETTLE, RUN; reset enters LOAD.
REQ-021 LOAD: ld_we with ld_addr word-aligned and < MEM_WORDS*4 SHALL write ld_wdata to word ld_addr>>2 at that edge; boot_words +1, saturating at 16'hFFFF.
REQ-022 LOAD: a misaligned or out-of-range ld_we SHALL be dropped (no write, no count) and SHALL set addr_err.
REQ-023 LOAD: ld_done=1 SHALL move to SETTLE next edge; a simultaneous ld_we SHALL still be accepted.
REQ-024 SETTLE: a down-counter loaded with RELEASE_DELAY SHALL move to RUN after exactly RELEASE_DELAY cycles; ld_we ignored.
REQ-025 cpu_rst_n SHALL be registered: 0 in LOAD/SETTLE, 1 from the first RUN cycle onward.
REQ-026 RUN: a read request SHALL return cpu_rdata with cpu_rvalid=1 on the next cycle (latency 1); cpu_rvalid=0 otherwise.
REQ-027 RUN: a write request SHALL update only strobed bytes and pulse cpu_rvalid next cycle; cpu_rdata is don't-care then.
REQ-028 Back-to-back write then read to the same word SHALL return the written data.
REQ-029 RUN: a misaligned or out-of-range CPU access SHALL not touch RAM, SHALL return cpu_rdata=0 with cpu_rvalid pulse, and SHALL set addr_err.
REQ-030 cpu_req outside RUN SHALL be ignored (no rvalid); ld_we/ld_done in RUN SHALL be ignored; RUN is left only by reset.

Reset
REQ-031 On rst_n=0: state LOAD, cpu_rst_n=0, cpu_rvalid=0, cpu_rdata=0, boot_words=0, boot_sum=0, addr_err=0, counter=RELEASE_DELAY.
REQ-032 RAM contents SHALL NOT be cleared by reset; reset mid-LOAD or mid-RUN SHALL abort and restart in LOAD.

Configuration
REQ-033 Macro BOOT_CHECKSUM_EN defined: boot_sum accumulates per REQ-018 on every accepted loader write, wrapping mod 2^32.
REQ-034 BOOT_CHECKSUM_EN undefined: no accumulator hardware; boot_sum tied to 32'h0.

Verification
REQ-035 Load words 0x00100093,0x00200113 at 0x0,0x4, ld_done -> boot_words=2, boot_sum=0x003001A6 (with BOOT_CHECKSUM_EN), cpu_rst_n=1 exactly 1+RELEASE_DELAY cycles after ld_done sampled.
REQ-036 In RUN read 0x4 -> next cycle cpu_rvalid=1, cpu_rdata=0x00200113, one cycle only.
REQ-037 ld_we at 0x2 and at MEM_WORDS*4 -> addr_err=1, boot_words unchanged, RAM unchanged.
REQ-038 RUN write 0xAABBCCDD to 0x0 with wstrb=4'b0101, then read 0x0 -> 0x00BB00DD (prior data 0).
REQ-039 ld_we and ld_done same cycle -> word written, boot_words incremented, SETTLE entered.
REQ-040 rst_n low mid-RUN -> cpu_rst_n=0, counters 0, previously loaded word still readable after reload sequence.
